mul_ctrl: RTL

MUL_CTRL -- requirements
Module: mul_ctrl

---
 rtl/mul_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mul_ctrl.sv
// Multicycle multiply controller: latches operands for an external multiplier and returns the selected 32-bit result.
// Optional MUL_ZERO_SKIP_EN: an op with a zero operand completes without waiting on the multiplier.
module mul_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic [4:0]  req_dest,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_dest,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic        signed_q, signed_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic        accept;

    assign req_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ready));
    assign accept    = req_valid && req_ready;

    // dest_q only changes on accept, which cannot happen while a result is stalled
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        signed_d = signed_q;
        op_d     = op_q;
        dest_d   = dest_q;
        data_d   = data_q;

        if ((state_q == S_DONE) && rsp_ready) begin
            state_d = S_IDLE;
        end

        if (accept) begin
            x_d      = req_src1;
            y_d      = req_src2;
            signed_d = (req_op != 2'b10);
            op_d     = req_op;
            dest_d   = req_dest;
            state_d  = S_BUSY;
            cnt_d    = 3'(MUL_LAT - 1);
`ifdef MUL_ZERO_SKIP_EN
            if ((req_src1 == 32'd0) || (req_src2 == 32'd0)) begin
                state_d = S_DONE;
                cnt_d   = 3'd0;
                data_d  = 32'd0;
            end
`endif
        end

        if (state_q == S_BUSY) begin
            if (cnt_q == 3'd0) begin
                state_d = S_DONE;
                data_d  = ((op_q == 2'b01) || (op_q == 2'b10)) ? mul_result[63:32]
                                                              : mul_result[31:0];
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            signed_q <= 1'b0;
            op_q     <= 2'b00;
            dest_q   <= 5'd0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            signed_q <= signed_d;
            op_q     <= op_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
        end
    end

    assign mul_x      = x_q;
    assign mul_y      = y_q;
    assign mul_signed = signed_q;
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_data   = data_q;
    assign rsp_dest   = dest_q;
    assign busy       = (state_q != S_IDLE);

endmodule
